// File: rtl/ballot_request_queue.sv
// ballot_request_queue: two-kiosk request collector and FIFO front-end for the
// avatar-election ballot unit. It emits one slot per clock. Slots with no
// request carry idle mode 2'b10. It also tracks the election phase from the
// number of slots emitted.
module ballot_request_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned REG_SLOTS  = 100,
  parameter int unsigned VOTE_SLOTS = 100
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       validA,
  input  logic [1:0] modeA,
  input  logic [5:0] userIDA,
  input  logic [1:0] candidateA,
  output logic       readyA,
  input  logic       validB,
  input  logic [1:0] modeB,
  input  logic [5:0] userIDB,
  input  logic [1:0] candidateB,
  output logic       readyB,
  output logic [1:0] mode,
  output logic [5:0] userID,
  output logic [1:0] candidate,
  output logic       slotValid,
  output logic       badRequest,
  output logic       full,
  output logic       empty,
  output logic [1:0] phase
);

  localparam int unsigned PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1);
  localparam int unsigned TOTAL_SLOTS = REG_SLOTS + VOTE_SLOTS;
  localparam int unsigned SC_W        = $clog2(TOTAL_SLOTS + 1);

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_t;

  typedef enum logic [1:0] {
    PH_REG    = 2'd0,
    PH_VOTE   = 2'd1,
    PH_CLOSED = 2'd2
  } phase_t;

  typedef struct packed {
    logic [1:0] md;
    logic [5:0] uid;
    logic [1:0] cand;
  } req_t;

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SC_W-1:0]  slot_count;
  rr_t              rr_q;
  rr_t              rr_d;
  phase_t           phase_w;

  req_t sel_req;
  req_t head;
  logic accept;
  logic push;
  logic pop;
  logic bad_d;
  logic full_w;

  assign full_w = (count == CNT_W'(DEPTH));
  assign full   = full_w;
  assign empty  = (count == '0);
  assign pop    = (count != '0);
  assign head   = mem[rd_ptr];
  assign phase  = phase_w;

  // Arbitration: one grant per cycle, round-robin when both kiosks are valid.
  // The grant is gated by reset and by full.
  always_comb begin
    readyA = 1'b0;
    readyB = 1'b0;
    if (!RST && !full_w) begin
      if (validA && (!validB || rr_q == RR_A)) begin
        readyA = 1'b1;
      end else if (validB) begin
        readyB = 1'b1;
      end
    end
  end

  // Request selection, enqueue/discard decision and next round-robin pointer.
  always_comb begin
    sel_req = readyB ? req_t'{md: modeB, uid: userIDB, cand: candidateB}
                     : req_t'{md: modeA, uid: userIDA, cand: candidateA};
    accept  = readyA | readyB;
    push    = accept && !sel_req.md[1];
    bad_d   = accept && sel_req.md[1];
    rr_d    = rr_q;
    if (accept && validA && validB) begin
      rr_d = (rr_q == RR_A) ? RR_B : RR_A;
    end
  end

  // Phase decode from the registered slot count.
  always_comb begin
    phase_w = PH_CLOSED;
    if (slot_count < SC_W'(REG_SLOTS)) begin
      phase_w = PH_REG;
    end else if (slot_count < SC_W'(TOTAL_SLOTS)) begin
      phase_w = PH_VOTE;
    end
  end

  // FIFO storage write. It needs no reset because count governs validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= sel_req;
    end
  end

  // Queue control, slot output register, bad-request pulse, phase counter.
  // The slot is loaded from the pre-edge head, so there is no empty bypass.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_q       <= RR_A;
      slot_count <= '0;
      mode       <= 2'b10;
      userID     <= '0;
      candidate  <= '0;
      slotValid  <= 1'b0;
      badRequest <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      badRequest <= bad_d;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        mode      <= head.md;
        userID    <= head.uid;
        candidate <= head.cand;
        slotValid <= 1'b1;
        rd_ptr    <= rd_ptr + PTR_W'(1);
      end else begin
        mode      <= 2'b10;
        userID    <= '0;
        candidate <= '0;
        slotValid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (slot_count < SC_W'(TOTAL_SLOTS)) begin
        slot_count <= slot_count + SC_W'(1);
      end
    end
  end

endmodule
